prio_arbiter: RTL

Parametrised, registered successor to the team's 4-to-2 combinational priority encoder. It captures request lines into a pending register and selects one index per handoff, using either fixed priority (highest index wins, as in the existing encoder) or round-robin. The chosen index is presented on a valid/ready output so downstream logic can apply backpressure. It sits between interrupt/event sources and a single consumer, such as a service FSM or a DMA channel select.

---
 rtl/prio_arbiter.sv | 50 +++++
 1 files changed

// File: rtl/prio_arbiter.sv
// prio_arbiter: registered fixed-priority or round-robin arbiter with pending register and valid/ready grant output
module prio_arbiter #(
  parameter int N = 8,
  parameter int W = $clog2(N),
  parameter int MODE = 0,
  parameter int STICKY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         clr,
  output logic [W-1:0] out_idx,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [N-1:0] pend,
  output logic         none
);
  logic [W-1:0] ptr;
  logic [W-1:0] sel;
  logic [N-1:0] mask;
  logic         load;
  logic         any;
  assign any  = |pend;
  assign none = ~any;
  assign load = ~out_vld | out_rdy;
  assign mask = (load && any) ? (N'(1) << sel) : '0;
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) if (pend[i]) sel = W'(i);
    if (MODE == 1) for (int i = 0; i < N; i++) if (pend[i] && W'(i) <= ptr) sel = W'(i);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pend    <= '0;
      out_vld <= 1'b0;
      out_idx <= '0;
      ptr     <= W'(N - 1);
    end else if (clr) begin
      pend    <= '0;
      out_vld <= 1'b0;
    end else begin
      pend <= (STICKY != 0) ? ((pend & ~mask) | req) : req;
      if (load) begin
        out_vld <= any;
        if (any) out_idx <= sel;
        if (any && MODE == 1) ptr <= (sel == '0) ? W'(N - 1) : sel - 1'b1;
      end
    end
  end
endmodule
